// File: rtl/pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// pwm_multi_channel
//
// N-channel PWM generator. All channels share one prescaler and one period
// counter. Each channel has a shadow duty register, written through a simple
// write port, and an active duty register. The active duty and active period
// are reloaded only at a period boundary (or continuously while disabled), so
// a running period is never truncated or glitched by a register update.
//
// Parameters
//   CHANNELS    number of PWM outputs (1..32)
//   WIDTH       width of the period counter, period and duty values
//   PRESCALE_W  width of the prescaler reload value
//   CH_W        (derived) width of the channel select, max(1, clog2(CHANNELS))
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous reset, active-high
//   en           run enable; 0 holds the counter and drives inactive levels
//   prescale     counter advances once every prescale+1 clocks
//   period       counter counts 0..period; sampled at period boundaries
//   polarity     per-channel invert; 1 = active-low output
//   wr_en        duty write strobe (single cycle)
//   wr_ch        channel index for the write; out-of-range indices are ignored
//   wr_duty      duty value in counter ticks
//   pwm_out      registered PWM outputs
//   cycle_start  one-clock pulse when a new period begins
// -----------------------------------------------------------------------------
module pwm_multi_channel #(
  parameter int  CHANNELS   = 8,
  parameter int  WIDTH      = 8,
  parameter int  PRESCALE_W = 8,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      period,
  input  logic [CHANNELS-1:0]   polarity,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [WIDTH-1:0]      wr_duty,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic                  cycle_start
);

  // ---------------------------------------------------------------------------
  // Shared timing state
  // ---------------------------------------------------------------------------
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [PRESCALE_W-1:0] presc_cnt_nxt;
  logic [WIDTH-1:0]      counter;
  logic [WIDTH-1:0]      counter_nxt;
  logic [WIDTH-1:0]      active_period;
  logic                  cycle_start_nxt;

  logic tick;         // counter advances on this clock
  logic boundary;     // last tick of the current period
  logic load_active;  // copy shadow values into the active registers

  // The prescaler compares for equality only. If prescale is lowered below the
  // running count, the count keeps incrementing, wraps through all-ones and
  // then meets the new value, which is the intended behaviour.
  assign tick        = (presc_cnt == prescale);
  assign boundary    = en && tick && (counter == active_period);

  // While disabled the active registers track their sources every clock, so a
  // later enable starts the first period with the most recent values.
  assign load_active = boundary || !en;

  // NOTE: every signal driven from always_comb gets a default on entry; a
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    presc_cnt_nxt   = '0;
    counter_nxt     = '0;
    cycle_start_nxt = 1'b0;
    if (en) begin
      presc_cnt_nxt = tick ? '0 : presc_cnt + PRESCALE_W'(1);
      if (boundary) begin
        counter_nxt     = '0;
        cycle_start_nxt = 1'b1;
      end else if (tick) begin
        counter_nxt = counter + WIDTH'(1);
      end else begin
        counter_nxt = counter;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register. The
  // per-channel duty load below relies on this to pick up the old shadow
  // value when a write and a boundary fall on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt     <= '0;
      counter       <= '0;
      active_period <= '1;
      cycle_start   <= 1'b0;
    end else begin
      presc_cnt   <= presc_cnt_nxt;
      counter     <= counter_nxt;
      cycle_start <= cycle_start_nxt;
      if (load_active) begin
        active_period <= period;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel duty registers and output stage
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_q;
    logic             wr_hit;
    logic             pwm_d;
    logic             pwm_q;

    // Only indices 0..CHANNELS-1 have a matching channel, so a write to a
    // non-existent channel simply hits nothing.
    assign wr_hit = wr_en && (int'(wr_ch) == i);

    // Unsigned compare: duty 0 never asserts, duty >= period+1 asserts for the
    // whole period including the wrap, since the counter never exceeds period.
    always_comb begin
      pwm_d = polarity[i];
      if (en) begin
        pwm_d = (counter < active_q) ^ polarity[i];
      end
    end

    // NOTE: the duty registers are a handful of flops, not a RAM, so they are
    // cleared by reset along with the rest of the state; nothing from an
    // aborted period survives a reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        shadow_q <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (wr_hit) begin
          shadow_q <= wr_duty;
        end
        if (load_active) begin
          active_q <= shadow_q;
        end
        pwm_q <= pwm_d;
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi_channel
//
// Self-checking bench for pwm_multi_channel with six channels, so that channel
// indices 6 and 7 are out of range. A cycle-level reference model pushes the
// expected pwm_out/cycle_start into a scoreboard queue each time stimulus is
// applied; the entry is popped and compared after the clock edge. A table of
// period/duty/polarity records is checked against closed-form high times and
// period lengths, and hand-written sequences cover enable, shadowing, invalid
// writes and reset in mid-period.
// -----------------------------------------------------------------------------
module tb_pwm_multi_channel;

  localparam int CHANNELS   = 6;
  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 8;
  localparam int CH_W       = 3;
  localparam int BUDGET     = 5000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      period;
  logic [CHANNELS-1:0]   polarity;
  logic                  wr_en;
  logic [CH_W-1:0]       wr_ch;
  logic [WIDTH-1:0]      wr_duty;
  logic [CHANNELS-1:0]   pwm_out;
  logic                  cycle_start;

  always #5 clk = ~clk;

  pwm_multi_channel #(
    .CHANNELS   (CHANNELS),
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .prescale    (prescale),
    .period      (period),
    .polarity    (polarity),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm_out     (pwm_out),
    .cycle_start (cycle_start)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [CHANNELS-1:0] pwm;
    logic                cs;
  } obs_t;

  obs_t sb_q[$];

  logic [PRESCALE_W-1:0] m_pc;
  logic [WIDTH-1:0]      m_cnt;
  logic [WIDTH-1:0]      m_per;
  logic [WIDTH-1:0]      m_sh  [CHANNELS];
  logic [WIDTH-1:0]      m_act [CHANNELS];
  logic [CHANNELS-1:0]   m_pwm;
  logic                  m_cs;

  // Advances the model by one clock using the inputs as they will be sampled
  // at the coming edge.
  task automatic model_step();
    logic [WIDTH-1:0] sh_next [CHANNELS];
    logic             tick;
    int               idx;
    if (rst) begin
      m_pc  = '0;
      m_cnt = '0;
      m_per = '1;
      m_pwm = '0;
      m_cs  = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        m_sh[c]  = '0;
        m_act[c] = '0;
      end
    end else begin
      sh_next = m_sh;
      idx     = int'(wr_ch);
      if (wr_en && idx < CHANNELS) sh_next[idx] = wr_duty;
      if (!en) begin
        m_pc  = '0;
        m_cnt = '0;
        m_cs  = 1'b0;
        m_pwm = polarity;
        m_per = period;
        m_act = m_sh;
      end else begin
        for (int c = 0; c < CHANNELS; c++) m_pwm[c] = (m_cnt < m_act[c]) ^ polarity[c];
        tick = (m_pc == prescale);
        m_cs = 1'b0;
        if (tick && m_cnt == m_per) begin
          m_cnt = '0;
          m_per = period;
          m_act = m_sh;
          m_cs  = 1'b1;
        end else if (tick) begin
          m_cnt = m_cnt + 8'd1;
        end
        m_pc = tick ? '0 : m_pc + 8'd1;
      end
      m_sh = sh_next;
    end
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic step();
    obs_t exp_o;
    obs_t got_o;
    model_step();
    exp_o.pwm = m_pwm;
    exp_o.cs  = m_cs;
    sb_q.push_back(exp_o);
    @(posedge clk);
    #1;
    got_o = sb_q.pop_front();
    check("pwm_out vs model", 32'(pwm_out), 32'(got_o.pwm));
    check("cycle_start vs model", 32'(cycle_start), 32'(got_o.cs));
  endtask

  task automatic wr(input int ch, input int duty);
    wr_en   = 1'b1;
    wr_ch   = CH_W'(ch);
    wr_duty = WIDTH'(duty);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_cs();
    int n = 0;
    do begin
      step();
      n++;
    end while (!cycle_start && n < BUDGET);
    if (!cycle_start) check("cycle_start wait timeout", 32'(cycle_start), 1);
  endtask

  // Starting just after a cycle_start edge, runs to the next cycle_start and
  // records the period length and the high clocks of every output. Optionally
  // issues one duty write before clock number wr_at of the window.
  int meas_len;
  int meas_high [CHANNELS];

  task automatic measure_period(input int wr_at, input int ch, input int duty);
    meas_len = 0;
    for (int c = 0; c < CHANNELS; c++) meas_high[c] = 0;
    do begin
      if (meas_len == wr_at) begin
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_duty = WIDTH'(duty);
      end
      step();
      wr_en = 1'b0;
      meas_len++;
      for (int c = 0; c < CHANNELS; c++) meas_high[c] += int'(pwm_out[c]);
    end while (!cycle_start && meas_len < BUDGET);
    if (!cycle_start) check("measure window timeout", 32'(cycle_start), 1);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: expected values from high = min(duty, period+1)*(prescale+1)
  // and length = (period+1)*(prescale+1); inverted channels report len - high.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      period;
    logic [CHANNELS-1:0]   pol;
    int                    duty     [4];
    int                    exp_len;
    int                    exp_high [4];
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input int ps, input int per, input int pol,
                         input int d0, input int d1, input int d2, input int d3,
                         input int len,
                         input int h0, input int h1, input int h2, input int h3);
    vec_t v;
    v.prescale    = PRESCALE_W'(ps);
    v.period      = WIDTH'(per);
    v.pol         = CHANNELS'(pol);
    v.duty[0]     = d0;
    v.duty[1]     = d1;
    v.duty[2]     = d2;
    v.duty[3]     = d3;
    v.exp_len     = len;
    v.exp_high[0] = h0;
    v.exp_high[1] = h1;
    v.exp_high[2] = h2;
    v.exp_high[3] = h3;
    vecs.push_back(v);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int               n;
    logic [CHANNELS-1:0] hi;

    //       ps  per  pol  duties            len  high times
    add_vec(0,   9,   0,   3, 0,   0,   0,   10,  3, 0,   0,  0);   // basic duty
    add_vec(0,   9,   0,   3, 0,  10, 255,   10,  3, 0,  10, 10);   // 0% and 100%
    add_vec(3,   4,   0,   2, 0,   5,   1,   20,  8, 0,  20,  4);   // prescaler
    add_vec(0,   9,   1,   3, 0,   0,   9,   10,  7, 0,   0,  9);   // ch0 active-low
    add_vec(1,   0,   0,   1, 0,   0,   0,    2,  2, 0,   0,  0);   // period 0
    add_vec(2, 255,   0, 128, 255, 0,   1,  768, 384, 765, 0, 3);   // full range

    rst      = 1'b1;
    en       = 1'b0;
    prescale = '0;
    period   = '0;
    polarity = '0;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_duty  = '0;

    // Reset state
    step();
    step();
    check("reset pwm_out", 32'(pwm_out), 0);
    check("reset cycle_start", 32'(cycle_start), 0);

    // Disabled: outputs sit at the polarity (inactive) level
    rst      = 1'b0;
    polarity = 6'b100101;
    repeat (3) step();
    check("disabled pwm_out = polarity", 32'(pwm_out), 32'(polarity));
    check("disabled cycle_start", 32'(cycle_start), 0);

    // Enable: first cycle_start at the end of the first full period
    polarity = '0;
    period   = 8'd9;
    prescale = '0;
    step();
    en = 1'b1;
    n  = 0;
    do begin
      step();
      n++;
    end while (!cycle_start && n < BUDGET);
    check("first cycle_start after enable", 32'(n), 10);

    // Table-driven duty/period/prescale/polarity checks
    foreach (vecs[k]) begin
      prescale = vecs[k].prescale;
      period   = vecs[k].period;
      polarity = vecs[k].pol;
      for (int c = 0; c < 4; c++) wr(c, vecs[k].duty[c]);
      wait_cs();
      measure_period(-1, 0, 0);
      check($sformatf("vec%0d period length", k), 32'(meas_len), 32'(vecs[k].exp_len));
      for (int c = 0; c < 4; c++)
        check($sformatf("vec%0d ch%0d high clocks", k, c), 32'(meas_high[c]), 32'(vecs[k].exp_high[c]));
    end

    // Shadowing: mid-period write and write on the boundary edge
    prescale = '0;
    period   = 8'd9;
    polarity = '0;
    wr(0, 2);
    wr(1, 0);
    wr(2, 0);
    wr(3, 0);
    wait_cs();
    measure_period(3, 0, 7);
    check("mid-period write: current period keeps old duty", 32'(meas_high[0]), 2);
    measure_period(-1, 0, 0);
    check("mid-period write: applies after next cycle_start", 32'(meas_high[0]), 7);
    measure_period(9, 0, 5);
    check("boundary write: window length", 32'(meas_len), 10);
    check("boundary write: window before boundary", 32'(meas_high[0]), 7);
    measure_period(-1, 0, 0);
    check("boundary write: next period still old duty", 32'(meas_high[0]), 7);
    measure_period(-1, 0, 0);
    check("boundary write: applies one period later", 32'(meas_high[0]), 5);

    // Writes to non-existent channels change nothing
    wr(6, 200);
    wr(7, 200);
    wait_cs();
    measure_period(-1, 0, 0);
    for (int c = 0; c < CHANNELS; c++)
      check($sformatf("invalid write: ch%0d high clocks", c), 32'(meas_high[c]), (c == 0) ? 5 : 0);

    // Disable while running
    polarity = 6'b000011;
    en       = 1'b0;
    step();
    check("en=0 mid-run pwm_out = polarity", 32'(pwm_out), 32'(polarity));
    check("en=0 mid-run cycle_start", 32'(cycle_start), 0);
    repeat (3) step();
    polarity = '0;
    en       = 1'b1;

    // Reset at counter = 5
    wait_cs();
    repeat (5) step();
    check("pre-reset output active", 32'(pwm_out[0]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid-op reset pwm_out", 32'(pwm_out), 0);
    check("mid-op reset cycle_start", 32'(cycle_start), 0);
    n  = 0;
    hi = '0;
    do begin
      step();
      n++;
      hi |= pwm_out;
    end while (!cycle_start && n < BUDGET);
    check("first period after reset uses all-ones period", 32'(n), 256);
    check("outputs inactive after reset", 32'(hi), 0);
    wr(0, 4);
    wait_cs();
    measure_period(-1, 0, 0);
    check("after reset: new duty length", 32'(meas_len), 10);
    check("after reset: new duty high clocks", 32'(meas_high[0]), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
- Parametrised N-channel PWM generator. All channels share one period counter. Each channel has its own duty register, loaded through a simple write port.
- Duty and period values are double-buffered. They take effect only at a period boundary, so a period is never truncated or glitched.
- Sits between the control logic (UART/button register file) and the LED/motor pins. Succeeds the fixed 8-bit single-channel generator.
- Adds exact 0% and 100% duty, a programmable period and a clock prescaler.

Parameters:
- CHANNELS, 8, number of independent PWM outputs (1..32).
- WIDTH, 8, bit width of the period counter, period and duty values.
- PRESCALE_W, 8, bit width of the prescaler reload value.
- CH_W (local), max(1, clog2(CHANNELS)), width of the channel select.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  run enable; 0 = counter held, outputs at inactive level.
- prescale  in  PRESCALE_W  counter advances once every prescale+1 clocks.
- period  in  WIDTH  counter counts 0..period; sampled only at boundaries.
- polarity  in  CHANNELS  per-channel invert; 1 = active-low output.
- wr_en  in  1  duty write strobe, single cycle.
- wr_ch  in  CH_W  channel index for the write.
- wr_duty  in  WIDTH  duty value in counter ticks.
- pwm_out  out  CHANNELS  registered PWM outputs.
- cycle_start  out  1  one-clock pulse when a new period begins.

Behaviour:
- Reset (rst=1 at clk edge):
  - prescaler count=0, period counter=0.
  - all shadow and active duties=0.
  - active period = 2^WIDTH-1.
  - pwm_out=0, cycle_start=0.
  - Reset mid-period aborts the period immediately; no partial state is retained.
- Prescaler:
  - tick=1 when prescaler count==prescale; the count then wraps to 0, otherwise it increments.
  - prescale=0 gives a tick every clock.
  - A prescale change takes effect against the running count; if the count is already above the new value, it runs up to all-ones and wraps before the next tick.
- Period counter:
  - On tick, counter increments.
  - Boundary = tick AND counter==active_period. At a boundary:
    - counter<=0.
    - active_period<=period.
    - every active duty <= its shadow duty.
    - cycle_start<=1 for exactly one clock.
  - period=0: every tick is a boundary; counter stays 0.
- Duty writes:
  - wr_en=1 stores wr_duty into shadow[wr_ch] on that edge.
  - wr_ch >= CHANNELS: write ignored.
  - A write on the same edge as a boundary lands in the shadow only. The active load on that edge uses the old shadow value, so the new value applies from the following period.
  - Writes are accepted regardless of en.
- Output:
  - raw[i] = (counter < active_duty[i]), unsigned compare.
  - pwm_out[i] <= raw[i] XOR polarity[i]; one clock latency from the counter.
  - duty=0 gives 0% active. duty >= period+1 gives 100% active, no glitch at wrap.
  - High time per period = min(duty, period+1) × (prescale+1) clocks.
  - Period length = (period+1) × (prescale+1) clocks.
- Enable:
  - en=0: prescaler and counter forced to 0, cycle_start=0, pwm_out = polarity (inactive level).
  - While en=0, the active period and duties are loaded from their inputs/shadows every clock.
  - en 0->1: the first period starts at counter 0 with the latest values; the first cycle_start fires at the end of that period.
- Polarity is not shadowed; it applies on the next edge.

Test Plan:
- Basic duty:
  - Setup: rst, then en=1, prescale=0, period=9, write ch0=3, wait one boundary.
  - Required: ch0 high exactly 3 of every 10 clocks; cycle_start period 10 clocks; other channels 0.
- Extremes:
  - Setup: ch1=0, ch2=10, ch3=255 with period=9.
  - Required: ch1 constantly 0; ch2 and ch3 constantly 1 across several wraps, no one-clock dips.
- Prescaler:
  - Setup: prescale=3, period=4, ch0=2.
  - Required: period 20 clocks; ch0 high 8 consecutive clocks per period.
- Shadowing:
  - Setup: ch0=2 running; write ch0=7 mid-period; separately, write ch0=5 on the exact boundary edge.
  - Required: mid-period write changes the output only after the next cycle_start; boundary write takes effect one full period later.
- Polarity/enable/invalid write:
  - Setup: polarity[0]=1, ch0=3, period=9; then en=0.
  - Required: ch0 low 3 of 10 clocks; with en=0, pwm_out = polarity vector.
  - Setup: wr_ch=CHANNELS (when CHANNELS is not a power of two).
  - Required: no shadow changes.
- Reset mid-operation:
  - Setup: assert rst at counter=5.
  - Required: next edge gives pwm_out=0, counter=0, all duties 0; after release, outputs stay inactive until new writes and a boundary.
